// File: rtl/sa_load_scheduler.sv
// Round-robin load sequencer for the systolic-array row buffers: grants each FIFO
// one BURST-word read burst, then fires compute and waits for the array to finish.
module sa_load_scheduler #(
  parameter int N_BUF  = 3,
  parameter int BURST  = 9,
  parameter int W_ADDR = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic [N_BUF-1:0]              i_fifo_empty,
  input  logic [N_BUF*(W_ADDR+1)-1:0]   i_occupants,
  input  logic                          i_compute_done,
  output logic [N_BUF-1:0]              o_read_enable,
  output logic [N_BUF-1:0]              o_sr_enable,
  output logic                          o_compute_start,
  output logic                          o_busy,
  output logic                          o_pass_done
);

  localparam int OW = W_ADDR + 1;
  localparam int CW = $clog2(BURST + 1);
  localparam int PW = (N_BUF > 1) ? $clog2(N_BUF) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_FIRE  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [N_BUF-1:0] loaded_q, loaded_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic [PW-1:0]    grant_q, grant_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_BUF-1:0] sr_q;

  logic [N_BUF-1:0] elig;
  logic [N_BUF-1:0] rd_en;
  logic             found;
  logic [PW-1:0]    pick;
  logic [PW-1:0]    cand;

  always_comb begin
    for (int k = 0; k < N_BUF; k++) begin
      elig[k] = !loaded_q[k] && !i_fifo_empty[k] &&
                (i_occupants[k*OW +: OW] >= OW'(BURST));
    end
  end

  // First eligible buffer at or after rr_q, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < N_BUF; i++) begin
      cand = PW'((int'(rr_q) + i) % N_BUF);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    rd_en = '0;
    if (state_q == S_LOAD && !i_fifo_empty[grant_q]) rd_en[grant_q] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    loaded_d = loaded_q;
    rr_d     = rr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          loaded_d = '0;
          state_d  = S_ARB;
        end
      end
      S_ARB: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (rd_en != '0) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(BURST - 1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        loaded_d[grant_q] = 1'b1;
        rr_d    = (grant_q == PW'(N_BUF - 1)) ? '0 : grant_q + PW'(1);
        state_d = (&loaded_d) ? S_FIRE : S_ARB;
      end
      S_FIRE:  state_d = S_WAIT;
      S_WAIT:  if (i_compute_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      loaded_q <= '0;
      rr_q     <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      sr_q     <= '0;
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      sr_q     <= rd_en;
    end
  end

  // FIFO data appears one cycle after the read strobe, so the shift enable lags it.
  assign o_read_enable   = rd_en;
  assign o_sr_enable     = sr_q;
  assign o_compute_start = (state_q == S_FIRE);
  assign o_busy          = (state_q != S_IDLE);
  assign o_pass_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_sa_load_scheduler.sv
// Scoreboard bench for sa_load_scheduler: directed passes queue expected strobe
// and pulse events; a negedge monitor pops and compares whenever an output is active.
module tb_sa_load_scheduler;

  localparam int N  = 3;
  localparam int B  = 9;
  localparam int WA = 8;
  localparam int OW = WA + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           cdone = 1'b0;
  logic [N-1:0]   empty = '0;
  logic [N*OW-1:0] occ = '0;
  logic [N-1:0]   rd_en, sr_en;
  logic           cstart, busy, pdone;

  sa_load_scheduler #(.N_BUF(N), .BURST(B), .W_ADDR(WA)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_fifo_empty   (empty),
    .i_occupants    (occ),
    .i_compute_done (cdone),
    .o_read_enable  (rd_en),
    .o_sr_enable    (sr_en),
    .o_compute_start(cstart),
    .o_busy         (busy),
    .o_pass_done    (pdone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           c;
    logic [N-1:0] v;
  } ev_t;

  ev_t rd_q[$];
  ev_t sr_q[$];
  ev_t cs_q[$];
  ev_t pd_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic set_occ(input int k, input int v);
    occ[k*OW +: OW] = OW'(v);
  endtask

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic exp_burst(input int idx, input int c0, input int n);
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(ev_t'{c0 + i, N'(1 << idx)});
      sr_q.push_back(ev_t'{c0 + i + 1, N'(1 << idx)});
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic match(input int which, input logic [N-1:0] got);
    ev_t   e;
    logic  have;
    string nm;
    have = 1'b0;
    e    = ev_t'{0, '0};
    case (which)
      0: begin nm = "rd_en";  if (rd_q.size() > 0) begin e = rd_q.pop_front(); have = 1'b1; end end
      1: begin nm = "sr_en";  if (sr_q.size() > 0) begin e = sr_q.pop_front(); have = 1'b1; end end
      2: begin nm = "cstart"; if (cs_q.size() > 0) begin e = cs_q.pop_front(); have = 1'b1; end end
      default: begin nm = "pdone"; if (pd_q.size() > 0) begin e = pd_q.pop_front(); have = 1'b1; end end
    endcase
    vectors++;
    if (!have) begin
      miscompares++;
      $display("FAIL %s unexpected: got %b at cycle %0d, expected no event", nm, got, cyc);
    end else if (e.c != cyc || e.v !== got) begin
      miscompares++;
      $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d", nm, got, cyc, e.v, e.c);
    end
  endtask

  task automatic drain(input string nm);
    int left;
    left = rd_q.size() + sr_q.size() + cs_q.size() + pd_q.size();
    vectors++;
    if (left != 0) begin
      miscompares++;
      $display("FAIL %s leftover: got %0d unconsumed expected events, expected 0", nm, left);
    end
    rd_q.delete();
    sr_q.delete();
    cs_q.delete();
    pd_q.delete();
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (rd_en != '0) match(0, rd_en);
      if (sr_en != '0) match(1, sr_en);
      if (cstart)      match(2, N'(1));
      if (pdone)       match(3, N'(1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    #1;
    chk("reset_outputs", {rd_en, sr_en, cstart, busy, pdone}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // compute_done while idle must not end a pass
    s = cyc;
    cdone = 1'b1;
    to_cyc(s + 1); cdone = 1'b0;
    to_cyc(s + 3); #1;
    chk("idle_no_pass_done", pdone, 0);
    chk("idle_busy", busy, 0);

    // full pass, all FIFOs ready; spurious start in LOAD/WAIT, done in FIRE
    to_cyc(cyc + 1);
    for (int k = 0; k < N; k++) set_occ(k, 9);
    s = cyc;
    exp_burst(0, s + 2, 9);
    exp_burst(1, s + 13, 9);
    exp_burst(2, s + 24, 9);
    cs_q.push_back(ev_t'{s + 34, N'(1)});
    pd_q.push_back(ev_t'{s + 41, N'(1)});
    start = 1'b1;
    to_cyc(s + 1);  start = 1'b0;
    to_cyc(s + 5);  start = 1'b1;
    to_cyc(s + 6);  start = 1'b0;
    to_cyc(s + 34); cdone = 1'b1;
    to_cyc(s + 35); cdone = 1'b0;
    to_cyc(s + 37); start = 1'b1;
    to_cyc(s + 38); start = 1'b0;
    to_cyc(s + 39); #1;
    chk("wait_busy", busy, 1);
    to_cyc(s + 40); cdone = 1'b1;
    to_cyc(s + 41); cdone = 1'b0; #1;
    chk("done_busy", busy, 1);
    to_cyc(s + 42); #1;
    chk("busy_drop", busy, 0);
    to_cyc(s + 44);
    drain("full_pass");

    // only FIFO2 ready; FIFO0/1 at 8 words until FIFO0 jumps to 511 and FIFO1 to 9
    to_cyc(cyc + 1);
    set_occ(0, 8); set_occ(1, 8); set_occ(2, 9);
    s = cyc;
    exp_burst(2, s + 2, 9);
    exp_burst(0, s + 21, 9);
    exp_burst(1, s + 32, 9);
    cs_q.push_back(ev_t'{s + 42, N'(1)});
    pd_q.push_back(ev_t'{s + 46, N'(1)});
    start = 1'b1;
    to_cyc(s + 1);  start = 1'b0;
    to_cyc(s + 19); #1;
    chk("occ8_not_granted", rd_en, 0);
    chk("occ8_busy", busy, 1);
    to_cyc(s + 20); set_occ(0, 511); set_occ(1, 9);
    to_cyc(s + 45); cdone = 1'b1;
    to_cyc(s + 46); cdone = 1'b0;
    to_cyc(s + 48);
    drain("round_robin");

    // reset in the middle of buffer 1's burst (order 2,0,1 since pointer sits at 2)
    to_cyc(cyc + 1);
    for (int k = 0; k < N; k++) set_occ(k, 9);
    s = cyc;
    exp_burst(2, s + 2, 9);
    exp_burst(0, s + 13, 9);
    exp_burst(1, s + 24, 2);
    rd_q.push_back(ev_t'{s + 26, N'(2)});
    start = 1'b1;
    to_cyc(s + 1);  start = 1'b0;
    to_cyc(s + 27); rst = 1'b1; #1;
    chk("reset_mid_load", {rd_en, sr_en, cstart, busy, pdone}, 0);
    to_cyc(s + 29); rst = 1'b0; #1;
    chk("reset_release_busy", busy, 0);
    to_cyc(s + 30);
    drain("reset");

    // stall: FIFO0 empty for cycles 5-7 of buffer 0's burst; pointer restarts at 0
    to_cyc(cyc + 1);
    s = cyc;
    exp_burst(0, s + 2, 3);
    exp_burst(0, s + 8, 6);
    exp_burst(1, s + 16, 9);
    exp_burst(2, s + 27, 9);
    cs_q.push_back(ev_t'{s + 37, N'(1)});
    pd_q.push_back(ev_t'{s + 41, N'(1)});
    start = 1'b1;
    to_cyc(s + 1);  start = 1'b0;
    to_cyc(s + 5);  empty[0] = 1'b1;
    to_cyc(s + 6);  #1;
    chk("stall_rd_low", rd_en, 0);
    to_cyc(s + 8);  empty[0] = 1'b0;
    to_cyc(s + 40); cdone = 1'b1;
    to_cyc(s + 41); cdone = 1'b0;
    to_cyc(s + 43); #1;
    chk("stall_end_busy", busy, 0);
    drain("stall");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
